rst_gen: RTL and testbench
==========================

# rst_gen

Reset generator sitting directly upstream of the reset sequencer: it takes the raw board reset and PLL lock, produces a clean, synchronously released, stretched hold-reset `seq_rst` that drives the sequencer's reset input, and re-applies it on loss of PLL lock or a software/watchdog request. While `seq_rst` is high the sequencer is held idle. Its falling edge starts the staged CPU/cache/BPU/AXI release.

## Interface
Parameters:
- `LOCK_CYCLES`, 16: consecutive synchronized-lock cycles required before stretching (≥1).
- `STRETCH_CYCLES`, 32: cycles `seq_rst` stays high after lock is qualified (≥1).
- `SOFT_CYCLES`, 8: extra hold cycles for a soft reset (≥1).
- `CNT_W`, 8: counter width; must hold max(parameter)−1.

Ports:
- `clk` in 1: single core clock.
- `rstn` in 1: asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronized internally.
- `pll_locked` in 1: asynchronous PLL lock status.
- `soft_req` in 1: synchronous single-cycle soft-reset request (watchdog/CSR).
- `seq_rst` out 1: active-high hold-reset to the sequencer; registered.
- `rst_done` out 1: high exactly when `seq_rst` is low.
- `rst_cause` out 2: last reset cause; 01 POR, 10 loss of lock, 11 soft; 00 unused.

## Operation
- Reset synchronizer: two flops, async-cleared by `rstn`, D=1. Output `rst_n_sync` asynchronously resets every other flop.
- Lock synchronizer: two flops on `pll_locked` (→ `lock_s`), cleared by `rst_n_sync`.
- Under reset: state=HOLD, cnt=0, `seq_rst`=1, `rst_done`=0, `rst_cause`=01.
- FSM states: HOLD, STRETCH, RUN, SOFT.
- HOLD: cnt increments each edge while `lock_s`=1 and clears when `lock_s`=0. The edge with cnt==LOCK_CYCLES−1 and `lock_s`=1 moves to STRETCH with cnt=0.
- STRETCH: cnt increments. cnt==STRETCH_CYCLES−1 → RUN, cnt=0. `lock_s`=0 → HOLD, cnt=0, cause unchanged.
- RUN: `lock_s`=0 → HOLD, cause=10. `soft_req`=1 → SOFT, cause=11. If both occur, loss of lock wins.
- SOFT: cnt increments. cnt==SOFT_CYCLES−1 → STRETCH, cnt=0. `lock_s`=0 → HOLD, cause=10.
- `soft_req` is ignored outside RUN and is not queued.
- `seq_rst` <= (next_state != RUN); `rst_done` = ~`seq_rst`.
- `rst_cause` is sticky and changes only on the transitions listed above or on `rstn`.

## Timing
- Edges are numbered from the first rising `clk` edge after `rstn` rises, with recovery met.
- `rstn` fall: `seq_rst` goes to 1 asynchronously, with no clock needed.
- Edge 2: `rst_n_sync` goes high.
- Edge 4: `lock_s` goes high, if `pll_locked` is already stable.
- Edge 4+LOCK_CYCLES: STRETCH is entered.
- Edge 4+LOCK_CYCLES+STRETCH_CYCLES: `seq_rst` falls. With defaults this is edge 52.
- Lock loss in RUN: `pll_locked` fall → `seq_rst` high on the third edge (two sync stages plus the output register).
- Soft reset: `seq_rst` rises on the edge sampling `soft_req`=1, then stays high for SOFT_CYCLES+STRETCH_CYCLES edges (40 with defaults).
- Lock glitch shorter than one synchronized cycle during HOLD: the count restarts from 0.
- `rstn` asserted mid-operation from any state returns to the reset values immediately.

## Configuration
- `RST_SOFT_REQ_EN` defined: soft reset behaves as described above.
- `RST_SOFT_REQ_EN` undefined: the `soft_req` port remains but is ignored, SOFT is unreachable, and `rst_cause` never reads 11.

## Structure
- Package `rst_pkg` holds:
  - state encoding enum: HOLD=0, STRETCH=1, RUN=2, SOFT=3;
  - cause constants: `CAUSE_POR`=2'b01, `CAUSE_LOL`=2'b10, `CAUSE_SOFT`=2'b11.
- Sub-module `rst_sync2`: generic two-flop synchronizer with async active-low clear. It is instantiated for `pll_locked`; the reset synchronizer is inline.

## Test plan
- POR with `pll_locked`=1 throughout, default parameters: `seq_rst`=1 through edge 51, falls at edge 52; `rst_done`=1 and `rst_cause`=01 afterwards.
- Lock toggling low for 1 cycle every 10 cycles after reset: the HOLD counter never reaches 15 and `seq_rst` stays 1. When toggling stops, `seq_rst` falls 16+32 edges after `lock_s` goes stable.
- In RUN, drop `pll_locked`: `seq_rst`=1 by the third edge and `rst_cause`=10. Restore lock: `seq_rst` falls 2+16+32 edges after the restore edge.
- In RUN, one-cycle `soft_req`: `seq_rst` high for exactly 40 edges and `rst_cause`=11. Repeat with the macro undefined: `seq_rst` stays 0 and the cause is unchanged.
- In RUN, `soft_req` and `lock_s` fall in the same cycle: state HOLD and `rst_cause`=10.
- Assert `rstn` for 3 ns in the middle of STRETCH, with no clock edge: `seq_rst`=1 immediately and `rst_cause`=01. After release, the full 52-edge sequence repeats.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared definitions for the reset generator: state encoding, reset-cause codes
// and the terminal-count helper used by the hold/stretch/soft counters.
package rst_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2,
        SOFT    = 2'd3
    } rst_state_e;

    localparam logic [CAUSE_W-1:0] CAUSE_POR  = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_LOL  = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_SOFT = 2'b11;

    // True on the last cycle of a window that is `cycles` long.
    function automatic logic cnt_at_last(input logic [31:0] cnt, input logic [31:0] cycles);
        return cnt == (cycles - 32'd1);
    endfunction

endpackage

// File: rtl/rst_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module rst_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_gen.sv
// Reset generator feeding the reset sequencer: qualifies PLL lock, stretches and
// re-applies seq_rst on lock loss or soft request (soft path only with RST_SOFT_REQ_EN).
module rst_gen
    import rst_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = 16,
    parameter int unsigned STRETCH_CYCLES = 32,
    parameter int unsigned SOFT_CYCLES    = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pll_locked,
    input  logic       soft_req,
    output logic       seq_rst,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam logic [STATE_W-1:0] S_HOLD    = STATE_W'(HOLD);
    localparam logic [STATE_W-1:0] S_STRETCH = STATE_W'(STRETCH);
    localparam logic [STATE_W-1:0] S_RUN     = STATE_W'(RUN);
    localparam logic [STATE_W-1:0] S_SOFT    = STATE_W'(SOFT);

    logic               rst_meta;
    logic               rst_n_sync;
    logic               lock_s;
    logic               soft_go;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CAUSE_W-1:0] cause_nxt;

    // Reset synchronizer: asynchronous assertion, release after two edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    rst_sync2 u_lock_sync (
        .clk  (clk),
        .rstn (rst_n_sync),
        .d    (pll_locked),
        .q    (lock_s)
    );

`ifdef RST_SOFT_REQ_EN
    assign soft_go = soft_req;
`else
    logic soft_req_unused;
    assign soft_req_unused = soft_req;
    assign soft_go         = 1'b0;
`endif

    // Next-state, counter and cause; lock loss has priority over everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cause_nxt = rst_cause;
        case (state)
            S_HOLD: begin
                if (!lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt_at_last(32'(cnt), 32'(LOCK_CYCLES))) begin
                    state_nxt = S_STRETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STRETCH: begin
                if (!lock_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt_at_last(32'(cnt), 32'(STRETCH_CYCLES))) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_LOL;
                end else if (soft_go) begin
                    state_nxt = S_SOFT;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_SOFT;
                end
            end
            S_SOFT: begin
                if (!lock_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_LOL;
                end else if (cnt_at_last(32'(cnt), 32'(SOFT_CYCLES))) begin
                    state_nxt = S_STRETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and outputs; seq_rst/rst_done follow next_state so release lands on the RUN edge.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state     <= S_HOLD;
            cnt       <= '0;
            seq_rst   <= 1'b1;
            rst_done  <= 1'b0;
            rst_cause <= CAUSE_POR;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            seq_rst   <= (state_nxt != S_RUN);
            rst_done  <= (state_nxt == S_RUN);
            rst_cause <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_rst_gen.sv
// Directed self-checking bench for rst_gen; soft-reset expectations follow RST_SOFT_REQ_EN.
module tb_rst_gen;

    logic       clk;
    logic       rstn;
    logic       pll_locked;
    logic       soft_req;
    logic       seq_rst;
    logic       rst_done;
    logic [1:0] rst_cause;

    int checks;
    int errors;

    rst_gen dut (
        .clk        (clk),
        .rstn       (rstn),
        .pll_locked (pll_locked),
        .soft_req   (soft_req),
        .seq_rst    (seq_rst),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges 1..52 after rstn release: seq_rst high through 51, low at 52.
    task automatic check_por_sequence(input string tag);
        for (int e = 1; e <= 52; e++) begin
            tick();
            checks++;
            if (seq_rst !== (e < 52)) begin
                errors++;
                $display("FAIL %s seq_rst edge %0d: got %b want %b", tag, e, seq_rst, (e < 52));
            end
            checks++;
            if (rst_done !== (e >= 52)) begin
                errors++;
                $display("FAIL %s rst_done edge %0d: got %b want %b", tag, e, rst_done, (e >= 52));
            end
        end
        checks++;
        if (rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL %s cause: got %b want 01", tag, rst_cause);
        end
    endtask

    // After lock is restored on edge r (driven just after it), seq_rst falls on r+50.
    task automatic check_restore(input string tag, input logic [1:0] cause_exp);
        for (int e = 1; e <= 50; e++) begin
            tick();
            checks++;
            if (seq_rst !== (e < 50)) begin
                errors++;
                $display("FAIL %s seq_rst restore+%0d: got %b want %b", tag, e, seq_rst, (e < 50));
            end
        end
        checks++;
        if (rst_done !== 1'b1 || rst_cause !== cause_exp) begin
            errors++;
            $display("FAIL %s done/cause: got %b/%b want 1/%b", tag, rst_done, rst_cause, cause_exp);
        end
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        pll_locked = 1'b1;
        soft_req   = 1'b0;
        #12;
        checks++;
        if (seq_rst !== 1'b1 || rst_done !== 1'b0 || rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL reset_values: got seq_rst=%b done=%b cause=%b want 1/0/01",
                     seq_rst, rst_done, rst_cause);
        end
        @(negedge clk);
        rstn = 1'b1;
        check_por_sequence("por");
    endtask

    task automatic test_lock_glitch();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        // One-cycle lock drop every 10 cycles; last drop released after edge 96.
        for (int cyc = 1; cyc <= 146; cyc++) begin
            tick();
            checks++;
            if (seq_rst !== (cyc < 146)) begin
                errors++;
                $display("FAIL glitch seq_rst cycle %0d: got %b want %b", cyc, seq_rst, (cyc < 146));
            end
            if (cyc <= 100) pll_locked = ((cyc % 10) != 5);
            else            pll_locked = 1'b1;
        end
    endtask

    task automatic test_lol();
        pll_locked = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (seq_rst !== (e == 3)) begin
                errors++;
                $display("FAIL lol seq_rst edge %0d: got %b want %b", e, seq_rst, (e == 3));
            end
        end
        checks++;
        if (rst_cause !== 2'b10 || rst_done !== 1'b0) begin
            errors++;
            $display("FAIL lol cause/done: got %b/%b want 10/0", rst_cause, rst_done);
        end
        tick();
        pll_locked = 1'b1;
        check_restore("lol", 2'b10);
    endtask

    task automatic test_soft();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
`ifdef RST_SOFT_REQ_EN
        checks++;
        if (seq_rst !== 1'b1 || rst_cause !== 2'b11) begin
            errors++;
            $display("FAIL soft_start: got seq_rst=%b cause=%b want 1/11", seq_rst, rst_cause);
        end
        for (int e = 1; e <= 45; e++) begin
            if (e == 5) soft_req = 1'b1;
            tick();
            soft_req = 1'b0;
            checks++;
            if (seq_rst !== (e < 40)) begin
                errors++;
                $display("FAIL soft seq_rst edge %0d: got %b want %b", e, seq_rst, (e < 40));
            end
        end
        checks++;
        if (rst_cause !== 2'b11) begin
            errors++;
            $display("FAIL soft cause_end: got %b want 11", rst_cause);
        end
`else
        for (int e = 0; e <= 45; e++) begin
            if (e == 5) soft_req = 1'b1;
            if (e > 0) tick();
            soft_req = 1'b0;
            checks++;
            if (seq_rst !== 1'b0 || rst_cause !== 2'b10) begin
                errors++;
                $display("FAIL soft_ignored edge %0d: got seq_rst=%b cause=%b want 0/10",
                         e, seq_rst, rst_cause);
            end
        end
`endif
    endtask

    task automatic test_soft_lol();
        pll_locked = 1'b0;
        tick();
        tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        checks++;
        if (seq_rst !== 1'b1 || rst_cause !== 2'b10) begin
            errors++;
            $display("FAIL soft_lol: got seq_rst=%b cause=%b want 1/10", seq_rst, rst_cause);
        end
        pll_locked = 1'b1;
        check_restore("soft_lol", 2'b10);
    endtask

    task automatic test_async_reset();
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        pll_locked = 1'b1;
        // Restore edge r; STRETCH spans r+18..r+49, stop at r+30.
        for (int e = 1; e <= 30; e++) tick();
        checks++;
        if (seq_rst !== 1'b1 || rst_cause !== 2'b10) begin
            errors++;
            $display("FAIL pre_async: got seq_rst=%b cause=%b want 1/10", seq_rst, rst_cause);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (seq_rst !== 1'b1 || rst_done !== 1'b0 || rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL async_reset: got seq_rst=%b done=%b cause=%b want 1/0/01",
                     seq_rst, rst_done, rst_cause);
        end
        #2;
        rstn = 1'b1;
        check_por_sequence("rerun");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lock_glitch();
        test_lol();
        test_soft();
        test_soft_lol();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
